// File: rtl/conv_tile_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_tile_buffer_if                                                      |
// | Bundle of host-load, engine fetch/write and host-drain signals shared    |
// | between the tile buffer (slave) and its host/engine side (master).       |
// | Ports: none beyond the bundled signals; clk/rst_n are routed separately. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface conv_tile_buffer_if #(
  parameter int DATA_W    = 128,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 64,
  parameter int ADDR_W    = 32
);
  localparam int IN_IDX_W  = $clog2(IN_DEPTH);
  localparam int OUT_IDX_W = $clog2(OUT_DEPTH);
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1);

  // host load
  logic                  host_wr_en;
  logic                  host_wr_sel;
  logic [IN_IDX_W-1:0]   host_wr_idx;
  logic [DATA_W-1:0]     host_wr_data;
  logic                  host_load_done;
  // engine side
  logic                  eng_ready;
  logic                  eng_rd_en;
  logic [ADDR_W-1:0]     eng_rd_addr;
  logic [DATA_W-1:0]     eng_pixels;
  logic [DATA_W-1:0]     eng_weights;
  logic                  eng_wr_en;
  logic [ADDR_W-1:0]     eng_wr_addr;
  logic [DATA_W-1:0]     eng_wr_data;
  logic                  eng_tile_done;
  // host drain
  logic                  drain_rd_en;
  logic [OUT_IDX_W-1:0]  drain_idx;
  logic [DATA_W-1:0]     drain_data;
  logic                  drain_valid;
  logic                  drain_release;
  // status
  logic                  tile_irq;
  logic [CNT_W-1:0]      out_count;
  logic                  busy;
  logic                  addr_err;

  modport master (
    output host_wr_en, host_wr_sel, host_wr_idx, host_wr_data, host_load_done,
    output eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data, eng_tile_done,
    output drain_rd_en, drain_idx, drain_release,
    input  eng_ready, eng_pixels, eng_weights, drain_data, drain_valid,
    input  tile_irq, out_count, busy, addr_err
  );

  modport slave (
    input  host_wr_en, host_wr_sel, host_wr_idx, host_wr_data, host_load_done,
    input  eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data, eng_tile_done,
    input  drain_rd_en, drain_idx, drain_release,
    output eng_ready, eng_pixels, eng_weights, drain_data, drain_valid,
    output tile_irq, out_count, busy, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/conv_tile_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_tile_buffer                                                         |
// | Memory-side responder for the conv engine tile interface: host loads     |
// | pixel/weight words, engine fetches (1-cycle latency) and writes output   |
// | words, host drains results after tile completion.                        |
// | Ports: clk, rst_n (async, active-low), bus (conv_tile_buffer_if.slave);  |
// |        rd_count/wr_count (16b) only when CONV_TILE_BUF_STATS_EN defined. |
// | Optional macro: CONV_TILE_BUF_STATS_EN - fetch/write statistics counters |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module conv_tile_buffer #(
  parameter int DATA_W    = 128,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 64,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_tile_buffer_if.slave   bus
`ifdef CONV_TILE_BUF_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  localparam int IN_IDX_W  = $clog2(IN_DEPTH);
  localparam int OUT_IDX_W = $clog2(OUT_DEPTH);
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1);
  localparam int WORD_W    = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] pix_mem [IN_DEPTH];
  logic [DATA_W-1:0] wgt_mem [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];

  // Byte address -> word index; range test uses the full word index so that
  // large addresses can never alias into the memories.
  logic [WORD_W-1:0] rd_word, wr_word;
  logic              rd_ok, wr_ok, rd_fire, wr_fire, host_bad, in_run, in_drain;

  assign rd_word  = bus.eng_rd_addr[ADDR_W-1:2];
  assign wr_word  = bus.eng_wr_addr[ADDR_W-1:2];
  assign rd_ok    = (bus.eng_rd_addr[1:0] == 2'b00) && (rd_word < WORD_W'(IN_DEPTH));
  assign wr_ok    = (bus.eng_wr_addr[1:0] == 2'b00) && (wr_word < WORD_W'(OUT_DEPTH));
  assign in_run   = (state == S_RUN);
  assign in_drain = (state == S_DRAIN);
  assign rd_fire  = in_run && bus.eng_rd_en;
  assign wr_fire  = in_run && bus.eng_wr_en;
  assign host_bad = bus.host_wr_en && (state != S_LOAD);

  assign bus.busy = (state == S_START) || (state == S_RUN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (bus.host_load_done) state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN:   if (bus.eng_tile_done)  state_nxt = S_DRAIN;
      S_DRAIN: if (bus.drain_release)  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // ---------------- memories (no reset) ----------------
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && bus.host_wr_en) begin
      if (bus.host_wr_sel) wgt_mem[bus.host_wr_idx] <= bus.host_wr_data;
      else                 pix_mem[bus.host_wr_idx] <= bus.host_wr_data;
    end
    if (wr_fire && wr_ok)
      out_mem[wr_word[OUT_IDX_W-1:0]] <= bus.eng_wr_data;
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eng_ready   <= 1'b0;
      bus.eng_pixels  <= '0;
      bus.eng_weights <= '0;
      bus.drain_data  <= '0;
      bus.drain_valid <= 1'b0;
      bus.tile_irq    <= 1'b0;
      bus.out_count   <= '0;
      bus.addr_err    <= 1'b0;
    end else begin
      // Registered from S_START so the pulse lands in the first S_RUN cycle.
      bus.eng_ready <= (state == S_START);
      bus.tile_irq  <= in_run && bus.eng_tile_done;

      if (rd_fire) begin
        if (rd_ok) begin
          bus.eng_pixels  <= pix_mem[rd_word[IN_IDX_W-1:0]];
          bus.eng_weights <= wgt_mem[rd_word[IN_IDX_W-1:0]];
        end else begin
          bus.eng_pixels  <= '0;
          bus.eng_weights <= '0;
        end
      end

      // S_RUN increments and S_DRAIN release are mutually exclusive by state.
      if (wr_fire && wr_ok) begin
        if (bus.out_count != CNT_W'(OUT_DEPTH))
          bus.out_count <= bus.out_count + CNT_W'(1);
      end else if (in_drain && bus.drain_release) begin
        bus.out_count <= '0;
      end

      if ((rd_fire && !rd_ok) || (wr_fire && !wr_ok) || host_bad)
        bus.addr_err <= 1'b1;

      bus.drain_valid <= in_drain && bus.drain_rd_en;
      if (in_drain && bus.drain_rd_en)
        bus.drain_data <= out_mem[bus.drain_idx];
    end
  end

`ifdef CONV_TILE_BUF_STATS_EN
  // Counters restart on the S_LOAD -> S_START transition, i.e. per tile run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if ((state == S_LOAD) && bus.host_load_done) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_fire && rd_ok && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (wr_fire && wr_ok && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_tile_buffer                                                      |
// | Self-checking bench: directed vector table, hand-written corner cases    |
// | and randomized traffic compared against a behavioural reference model.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_conv_tile_buffer;
  localparam int DATA_W = 128, IN_DEPTH = 16, OUT_DEPTH = 64, ADDR_W = 32;
  localparam int P_LOAD = 0, P_START = 1, P_RUN = 2, P_DRAIN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv_tile_buffer_if #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
                        .ADDR_W(ADDR_W)) bus ();
`ifdef CONV_TILE_BUF_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  conv_tile_buffer #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
                     .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CONV_TILE_BUF_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int           m_phase;
  logic [127:0] m_pix [IN_DEPTH];
  logic [127:0] m_wgt [IN_DEPTH];
  logic [127:0] m_out [OUT_DEPTH];
  bit           m_pix_k [IN_DEPTH];
  bit           m_wgt_k [IN_DEPTH];
  bit           m_out_k [OUT_DEPTH];
  logic [127:0] m_pixels, m_weights, m_ddata;
  bit           m_pixels_k, m_weights_k, m_ddata_k;
  bit           m_ready, m_irq, m_dvalid, m_err;
  int           m_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_LOAD;
    m_pixels = '0; m_weights = '0; m_ddata = '0;
    m_pixels_k = 1; m_weights_k = 1; m_ddata_k = 1;
    m_ready = 0; m_irq = 0; m_dvalid = 0; m_err = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    int          nphase;
    int unsigned idx;
    bit          n_ready, n_irq, n_dvalid;
    nphase   = m_phase;
    n_ready  = (m_phase == P_START);
    n_irq    = 0;
    n_dvalid = 0;
    case (m_phase)
      P_LOAD: begin
        if (bus.host_wr_en) begin
          if (bus.host_wr_sel) begin
            m_wgt[bus.host_wr_idx] = bus.host_wr_data; m_wgt_k[bus.host_wr_idx] = 1;
          end else begin
            m_pix[bus.host_wr_idx] = bus.host_wr_data; m_pix_k[bus.host_wr_idx] = 1;
          end
        end
        if (bus.host_load_done) nphase = P_START;
      end
      P_START: nphase = P_RUN;
      P_RUN: begin
        if (bus.eng_rd_en) begin
          idx = bus.eng_rd_addr / 4;
          if ((bus.eng_rd_addr % 4 == 0) && (idx < IN_DEPTH)) begin
            m_pixels = m_pix[idx];  m_pixels_k  = m_pix_k[idx];
            m_weights = m_wgt[idx]; m_weights_k = m_wgt_k[idx];
          end else begin
            m_pixels = '0; m_weights = '0; m_pixels_k = 1; m_weights_k = 1; m_err = 1;
          end
        end
        if (bus.eng_wr_en) begin
          idx = bus.eng_wr_addr / 4;
          if ((bus.eng_wr_addr % 4 == 0) && (idx < OUT_DEPTH)) begin
            m_out[idx] = bus.eng_wr_data; m_out_k[idx] = 1;
            if (m_cnt < OUT_DEPTH) m_cnt++;
          end else m_err = 1;
        end
        if (bus.eng_tile_done) begin
          n_irq = 1; nphase = P_DRAIN;
        end
      end
      default: begin
        if (bus.drain_rd_en) begin
          n_dvalid  = 1;
          m_ddata   = m_out[bus.drain_idx];
          m_ddata_k = m_out_k[bus.drain_idx];
        end
        if (bus.drain_release) begin
          nphase = P_LOAD; m_cnt = 0;
        end
      end
    endcase
    if (bus.host_wr_en && (m_phase != P_LOAD)) m_err = 1;
    m_ready = n_ready; m_irq = n_irq; m_dvalid = n_dvalid; m_phase = nphase;
  endtask

  task automatic compare_all();
    chk("eng_ready",   bus.eng_ready,   m_ready);
    chk("tile_irq",    bus.tile_irq,    m_irq);
    chk("drain_valid", bus.drain_valid, m_dvalid);
    chk("out_count",   bus.out_count,   m_cnt);
    chk("busy",        bus.busy,        (m_phase == P_START) || (m_phase == P_RUN));
    chk("addr_err",    bus.addr_err,    m_err);
    if (m_pixels_k)  chk("eng_pixels",  bus.eng_pixels,  m_pixels);
    if (m_weights_k) chk("eng_weights", bus.eng_weights, m_weights);
    if (m_ddata_k)   chk("drain_data",  bus.drain_data,  m_ddata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.host_wr_en = 0; bus.host_wr_sel = 0; bus.host_wr_idx = '0; bus.host_wr_data = '0;
    bus.host_load_done = 0;
    bus.eng_rd_en = 0; bus.eng_rd_addr = '0; bus.eng_wr_en = 0; bus.eng_wr_addr = '0;
    bus.eng_wr_data = '0; bus.eng_tile_done = 0;
    bus.drain_rd_en = 0; bus.drain_idx = '0; bus.drain_release = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    idle();
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic host_write(input bit sel, input int idx, input logic [127:0] data);
    bus.host_wr_en = 1; bus.host_wr_sel = sel;
    bus.host_wr_idx = 4'(idx); bus.host_wr_data = data;
  endtask

  function automatic logic [31:0] rand_addr(input int range);
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0)      return $urandom();
    else if (r == 1) return ($urandom_range(0, range - 1) * 4) + $urandom_range(1, 3);
    else             return $urandom_range(0, range + 3) * 4;
  endfunction

  typedef struct {
    bit           rd_en;
    logic [31:0]  rd_addr;
    bit           wr_en;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic [127:0] exp_pix;
    logic [127:0] exp_wgt;
    bit           exp_err;
    int           exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h8,  1'b0, 32'h0,   128'h0,  128'hA2, 128'hB2, 1'b0, 0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 32'h0,   128'h0,  128'hA2, 128'hB2, 1'b0, 0};
    vecs[2] = '{1'b1, 32'h0,  1'b0, 32'h0,   128'h0,  128'hA0, 128'hB0, 1'b0, 0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 32'h0,   128'hC0, 128'hA0, 128'hB0, 1'b0, 1};
    vecs[4] = '{1'b1, 32'hC,  1'b1, 32'h4,   128'hC1, 128'hA3, 128'hB3, 1'b0, 2};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 32'h8,   128'hC2, 128'hA3, 128'hB3, 1'b0, 3};
    vecs[6] = '{1'b1, 32'h40, 1'b0, 32'h0,   128'h0,  128'h0,  128'h0,  1'b1, 3};
    vecs[7] = '{1'b0, 32'h0,  1'b1, 32'h102, 128'hDD, 128'h0,  128'h0,  1'b1, 3};

    idle();
    model_reset();
    apply_reset();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_count", bus.out_count, 7'd0);

    // ---- load tile; last weight write coincides with load_done ----
    for (int i = 0; i < 4; i++) begin
      host_write(1'b0, i, 128'hA0 + 128'(i));
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      host_write(1'b1, i, 128'hB0 + 128'(i));
      cycle();
    end
    host_write(1'b1, 3, 128'hB3);
    bus.host_load_done = 1;
    cycle();
    chk("ready_not_yet", bus.eng_ready, 1'b0);
    chk("busy_start", bus.busy, 1'b1);
    idle();
    cycle();
    chk("ready_pulse", bus.eng_ready, 1'b1);
    cycle();
    chk("ready_one_cycle", bus.eng_ready, 1'b0);

    // ---- vector table in S_RUN ----
    for (int i = 0; i < 8; i++) begin
      bus.eng_rd_en = vecs[i].rd_en; bus.eng_rd_addr = vecs[i].rd_addr;
      bus.eng_wr_en = vecs[i].wr_en; bus.eng_wr_addr = vecs[i].wr_addr;
      bus.eng_wr_data = vecs[i].wr_data;
      cycle();
      chk($sformatf("vec%0d_pix", i), bus.eng_pixels, vecs[i].exp_pix);
      chk($sformatf("vec%0d_wgt", i), bus.eng_weights, vecs[i].exp_wgt);
      chk($sformatf("vec%0d_err", i), bus.addr_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_cnt", i), bus.out_count, 7'(vecs[i].exp_cnt));
    end
    idle();

    // ---- write in the same cycle as tile_done ----
    bus.eng_wr_en = 1; bus.eng_wr_addr = 32'hC; bus.eng_wr_data = 128'hC3;
    bus.eng_tile_done = 1;
    cycle();
    chk("irq_pulse", bus.tile_irq, 1'b1);
    chk("count_4", bus.out_count, 7'd4);
    idle();
    bus.eng_rd_en = 1; bus.eng_rd_addr = 32'h0;   // ignored outside S_RUN
    cycle();
    chk("irq_once", bus.tile_irq, 1'b0);
    chk("fetch_ignored", bus.eng_pixels, 128'h0);
    idle();

    // ---- drain ----
    bus.drain_rd_en = 1; bus.drain_idx = 6'd1;
    cycle();
    chk("drain_c1_valid", bus.drain_valid, 1'b1);
    chk("drain_c1", bus.drain_data, 128'hC1);
    bus.drain_idx = 6'd3;
    cycle();
    chk("drain_c3", bus.drain_data, 128'hC3);
    idle();
    cycle();
    chk("drain_valid_off", bus.drain_valid, 1'b0);
    bus.drain_release = 1;
    cycle();
    chk("release_count", bus.out_count, 7'd0);
    idle();
    bus.drain_rd_en = 1;
    cycle();
    chk("drain_outside", bus.drain_valid, 1'b0);
    idle();

    // ---- rerun, reset mid-run after two writes ----
    bus.host_load_done = 1;
    cycle();
    idle();
    cycle();
    bus.eng_wr_en = 1; bus.eng_wr_addr = 32'h10; bus.eng_wr_data = 128'hE0;
    cycle();
    bus.eng_wr_addr = 32'h14; bus.eng_wr_data = 128'hE1;
    cycle();
    chk("run_count_2", bus.out_count, 7'd2);
    apply_reset();
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_count", bus.out_count, 7'd0);
    chk("midreset_ready", bus.eng_ready, 1'b0);
    chk("midreset_err", bus.addr_err, 1'b0);
    bus.host_load_done = 1;
    cycle();
    idle();
    cycle();
    chk("restart_ready", bus.eng_ready, 1'b1);
    bus.eng_rd_en = 1; bus.eng_rd_addr = 32'h4;   // memories survive reset
    cycle();
    chk("retained_pix", bus.eng_pixels, 128'hA1);
    idle();

    // ---- randomized traffic ----
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
        continue;
      end
      bus.host_wr_en   = (m_phase == P_LOAD) ? ($urandom_range(0, 1) == 1)
                                             : ($urandom_range(0, 63) == 0);
      bus.host_wr_sel  = 1'($urandom_range(0, 1));
      bus.host_wr_idx  = 4'($urandom_range(0, 15));
      bus.host_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.host_load_done = ($urandom_range(0, 7) == 0);
      bus.eng_rd_en    = ($urandom_range(0, 1) == 1);
      bus.eng_rd_addr  = rand_addr(IN_DEPTH);
      bus.eng_wr_en    = ($urandom_range(0, 1) == 1);
      bus.eng_wr_addr  = rand_addr(OUT_DEPTH);
      bus.eng_wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.eng_tile_done = ($urandom_range(0, 15) == 0);
      bus.drain_rd_en  = ($urandom_range(0, 1) == 1);
      bus.drain_idx    = 6'($urandom_range(0, 63));
      bus.drain_release = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_tile_buffer.md
Name: conv_tile_buffer

Overview:
- Memory-side responder for the convolution engine's BRAM-style tile interface.
- Host side: the host loads a tile of input pixels and weights, then the block pulses the engine's `ready`.
- Engine side: the block serves `read_en` fetches with 1-cycle latency and captures the engine's output-pixel writes.
- Once the engine signals tile completion, the host drains the results.
- Sits between the DMA/host wrapper and the conv engine top.

Parameters:
- DATA_W, 128, width of pixel, weight and output words.
- IN_DEPTH, 16, words in each of the pixel and weight memories.
- OUT_DEPTH, 64, words in the output memory.
- ADDR_W, 32, engine byte-address width; word index = addr >> 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_wr_en  in  1  host load strobe
- host_wr_sel  in  1  0 = pixel memory, 1 = weight memory
- host_wr_idx  in  $clog2(IN_DEPTH)  host load word index
- host_wr_data  in  DATA_W  host load data
- host_load_done  in  1  pulse: tile fully loaded
- eng_ready  out  1  start pulse to engine
- eng_rd_en  in  1  engine fetch strobe
- eng_rd_addr  in  ADDR_W  engine fetch byte address
- eng_pixels  out  DATA_W  fetched pixel word
- eng_weights  out  DATA_W  fetched weight word
- eng_wr_en  in  1  engine output write strobe
- eng_wr_addr  in  ADDR_W  engine output byte address
- eng_wr_data  in  DATA_W  engine output word
- eng_tile_done  in  1  engine tile-complete pulse
- drain_rd_en  in  1  host output read strobe
- drain_idx  in  $clog2(OUT_DEPTH)  host output word index
- drain_data  out  DATA_W  output word, 1-cycle latency
- drain_valid  out  1  drain_data valid
- drain_release  in  1  host finished draining
- tile_irq  out  1  1-cycle pulse on tile done
- out_count  out  $clog2(OUT_DEPTH+1)  output words written this tile
- busy  out  1  high in S_START/S_RUN
- addr_err  out  1  sticky error flag

Behaviour:
- Reset values: eng_ready=0, eng_pixels=0, eng_weights=0, drain_data=0, drain_valid=0, tile_irq=0, out_count=0, busy=0, addr_err=0, state=S_LOAD. Memory arrays are not reset.
- FSM states: S_LOAD, S_START, S_RUN, S_DRAIN.
- S_LOAD:
  - host_wr_en writes host_wr_data into the memory chosen by host_wr_sel at host_wr_idx.
  - host_load_done moves the FSM to S_START.
  - A write and load_done in the same cycle: the write is committed first.
- S_START: eng_ready=1 for exactly one cycle, then S_RUN.
- S_RUN fetches:
  - eng_rd_en at cycle N: eng_pixels and eng_weights are valid from N+1 and hold until the next fetch.
  - Both come from the same word index, eng_rd_addr>>2.
  - An index >= IN_DEPTH, or addr[1:0] != 0, returns 0 on both buses and sets addr_err.
- S_RUN writes:
  - eng_wr_en stores eng_wr_data at eng_wr_addr>>2 and increments out_count, saturating at OUT_DEPTH.
  - An out-of-range or misaligned write is dropped and sets addr_err.
- Host writes during S_START, S_RUN or S_DRAIN are ignored and set addr_err.
- eng_tile_done in S_RUN: tile_irq pulses next cycle, then S_DRAIN.
  - An eng_wr_en in the same cycle is still committed.
  - A fetch in the same cycle is still served.
- eng_rd_en, eng_wr_en and eng_tile_done outside S_RUN are ignored. No data or counter change, and no error.
- S_DRAIN:
  - drain_rd_en at cycle N gives drain_data = out_mem[drain_idx] with drain_valid=1 at N+1.
  - drain_valid=0 otherwise.
  - drain_release moves the FSM to S_LOAD and clears out_count.
  - Output memory contents persist; pixel and weight memories are retained, so the same tile can be rerun.
- drain_rd_en outside S_DRAIN: drain_valid stays 0.
- addr_err clears only on reset.
- Reset mid-operation returns to S_LOAD immediately with all outputs at reset values.
- No backpressure to the engine: fetches and writes complete every cycle.

Optional Feature:
- Macro: CONV_TILE_BUF_STATS_EN.
- With it defined:
  - Adds output ports rd_count and wr_count, each 16 bits.
  - rd_count counts accepted in-range engine fetches; wr_count counts accepted in-range engine writes.
  - Both clear on entry to S_START and saturate at 16'hFFFF.
- Without it: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load: pixel words 0..3 = 128'hA0..A3, weight words 0..3 = 128'hB0..B3, then load_done -> eng_ready high for exactly 1 cycle, 2 cycles after load_done; busy=1.
- Fetch: eng_rd_en with addr 32'h8 -> next cycle eng_pixels=128'hA2, eng_weights=128'hB2, held until the next fetch.
- Write/drain: engine writes addr 0x0,0x4,0x8 with data C0,C1,C2, then tile_done -> tile_irq pulses once, out_count=3; drain idx 1 -> drain_data=C1, drain_valid 1 cycle later.
- Errors: fetch at addr 0x40 (index 16) -> both buses 0, addr_err=1; engine write at 0x102 dropped, out_count unchanged.
- Simultaneous: eng_wr_en (addr 0xC, data C3) in the same cycle as eng_tile_done -> C3 is drained at idx 3, out_count=4.
- Reset in S_RUN after 2 writes -> state S_LOAD, out_count=0, eng_ready=0. A new load_done restarts normally.
